// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner.
//   scan_state_t : scanner FSM states
//   code_w()     : width of a key code for a rows x cols matrix (never below 1)
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    function automatic int code_w(input int rows, input int cols);
        int n;
        n = rows * cols;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small key-code queue with a registered head.
//   clk, rst      : clock, async active-high reset
//   push_i, din_i : write request and data; dropped when full unless popping
//   pop_i         : advance the head (ignored when empty)
//   dout_o        : head value; keeps its last value once the queue drains
//   full_o/empty_o: occupancy flags
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     head_q, head_d;
    logic             wr_en, rd_en;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = head_q;

    always_comb begin
        // A full queue still accepts a write when the head leaves in the same cycle.
        wr_en  = push_i && (!full_o || pop_i);
        rd_en  = pop_i && !empty_o;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (wr_en) begin
            wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (rd_en) begin
            rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Head register: the next stored entry if one exists, else the incoming code.
        if (empty_o) begin
            if (wr_en) begin
                head_d = din_i;
            end
        end else if (rd_en) begin
            if (cnt_q > CNT_W'(1)) begin
                head_d = mem_q[rd_d];
            end else if (wr_en) begin
                head_d = din_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= din_i;
            end
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/keypad_scanner_fifo.sv
// Matrix keypad scanner with press/release debounce and a key-code queue.
//   clk, rst     : clock, async active-high reset
//   row_i        : raw active-low rows (asynchronous)
//   col_o        : one-hot active-low column drive
//   key_code_o   : queue head code, row*COLS+col
//   key_valid_o  : queue non-empty; popped when key_ready_i is also high
//   key_held_o   : a debounced key is being held
//   overflow_o   : sticky, a code was dropped on a full queue; ovf_clr_i clears
//
// state    | meaning
// SCAN     | stepping columns one per tick, looking for an active row
// DEBOUNCE | column frozen, counting stable ticks of the latched row
// HELD     | code queued, column frozen, counting stable release ticks
module keypad_scanner_fifo
    import keypad_pkg::*;
#(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int SCAN_DIV   = 13500,
    parameter  int DEB_CYCLES = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int CODE_W     = code_w(ROWS, COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row_i,
    output logic [COLS-1:0]   col_o,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_valid_o,
    input  logic              key_ready_i,
    output logic              key_held_o,
    output logic              overflow_o,
    input  logic              ovf_clr_i
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = $clog2(COLS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [ROWS-1:0]   row_meta_q, row_sync_q;
    logic [PRE_W-1:0]  presc_q;
    logic              tick;
    scan_state_t       state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d, col_adv;
    logic [ROW_W-1:0]  row_q, row_d, row_sel;
    logic              row_any;
    logic [CNT_W-1:0]  deb_q, deb_d, rel_q, rel_d;
    logic              push, pop, full, empty;
    logic [CODE_W-1:0] push_code;
    logic              ovf_q, ovf_d;

    function automatic logic [CODE_W-1:0] enc(input logic [ROW_W-1:0] r,
                                              input logic [COL_W-1:0] c);
        return CODE_W'(int'(r) * COLS + int'(c));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
        end
    end

    assign tick = (presc_q == PRE_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    // Lowest-index active row wins, so simultaneous presses resolve deterministically.
    always_comb begin
        row_any = 1'b0;
        row_sel = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!row_sync_q[i]) begin
                row_any = 1'b1;
                row_sel = ROW_W'(i);
            end
        end
    end

    assign col_adv = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        deb_d     = deb_q;
        rel_d     = rel_q;
        push      = 1'b0;
        push_code = enc(row_q, col_q);
        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (row_any) begin
                        row_d = row_sel;
                        deb_d = CNT_W'(1);
                        if (DEB_CYCLES == 1) begin
                            push      = 1'b1;
                            push_code = enc(row_sel, col_q);
                            rel_d     = '0;
                            state_d   = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_adv;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (row_any && (row_sel == row_q)) begin
                        deb_d = deb_q + 1'b1;
                        if (deb_q + 1'b1 == CNT_W'(DEB_CYCLES)) begin
                            push    = 1'b1;
                            rel_d   = '0;
                            state_d = HELD;
                        end
                    end else begin
                        col_d   = col_adv;
                        state_d = SCAN;
                    end
                end
            end
            HELD: begin
                if (tick) begin
                    if (row_sync_q[row_q]) begin
                        rel_d = rel_q + 1'b1;
                        if (rel_q + 1'b1 == CNT_W'(DEB_CYCLES)) begin
                            col_d   = col_adv;
                            state_d = SCAN;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN;
            col_q   <= '0;
            row_q   <= '0;
            deb_q   <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            deb_q   <= deb_d;
            rel_q   <= rel_d;
        end
    end

    assign pop = key_valid_o && key_ready_i;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_code),
        .pop_i   (pop),
        .dout_o  (key_code_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // Set wins over clear so a drop in the clearing cycle is not lost.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign col_o       = ~(COLS'(1) << col_q);
    assign key_valid_o = !empty;
    assign key_held_o  = (state_q == HELD);
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner_fifo.sv
module tb_keypad_scanner_fifo;

    logic       clk;
    logic       rst;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_ready_i;
    logic       key_held_o;
    logic       overflow_o;
    logic       ovf_clr_i;

    int n_vec  = 0;
    int n_miss = 0;

    // Keypad model: up to two pressed keys, each pulls its row low while its column is driven.
    logic       ka_en, kb_en;
    int         ka_r, ka_c, kb_r, kb_c;
    logic       ovr_en;
    logic [3:0] ovr_val;
    logic [3:0] row_model;

    always_comb begin
        row_model = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (ka_en && ka_r == r && col_o[ka_c] == 1'b0) row_model[r] = 1'b0;
            if (kb_en && kb_r == r && col_o[kb_c] == 1'b0) row_model[r] = 1'b0;
        end
    end

    assign row_i = ovr_en ? ovr_val : row_model;

    keypad_scanner_fifo #(
        .ROWS       (4),
        .COLS       (4),
        .SCAN_DIV   (4),
        .DEB_CYCLES (3),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_code_o  (key_code_o),
        .key_valid_o (key_valid_o),
        .key_ready_i (key_ready_i),
        .key_held_o  (key_held_o),
        .overflow_o  (overflow_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_held(input logic v, input string tag);
        int n = 0;
        while (key_held_o !== v && n < 300) begin
            step();
            n++;
        end
        check(tag, {31'd0, key_held_o}, {31'd0, v});
    endtask

    // Returns just after the edge on which col_o becomes target.
    task automatic wait_col(input logic [3:0] target, input string tag);
        int n = 0;
        while (col_o === target && n < 100) begin
            step();
            n++;
        end
        while (col_o !== target && n < 100) begin
            step();
            n++;
        end
        check(tag, {28'd0, col_o}, {28'd0, target});
    endtask

    task automatic press_release(input int r, input int c, input string tag);
        ka_r  = r;
        ka_c  = c;
        ka_en = 1'b1;
        wait_held(1'b1, {tag, "_press"});
        ka_en = 1'b0;
        wait_held(1'b0, {tag, "_release"});
    endtask

    task automatic pop_one();
        key_ready_i = 1'b1;
        step();
        key_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        key_ready_i = 1'b0;
        ovf_clr_i = 1'b0;
        ka_en = 1'b0; kb_en = 1'b0;
        ka_r = 0; ka_c = 0; kb_r = 0; kb_c = 0;
        ovr_en = 1'b0;
        ovr_val = 4'b1111;

        // 1: reset release and idle scanning
        #12 rst = 1'b0;
        #1;
        check("rst_col", col_o, 4'b1110);
        check("rst_valid", key_valid_o, 1'b0);
        check("rst_code", key_code_o, 4'd0);
        check("rst_held", key_held_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        repeat (3) step();
        check("idle_col_3clk", col_o, 4'b1110);
        step();
        check("idle_col_4clk", col_o, 4'b1101);
        repeat (12) step();
        check("idle_col_16clk", col_o, 4'b1110);
        check("idle_valid", key_valid_o, 1'b0);

        // 2: key row2/col1 held with consumer stalled
        ka_r = 2; ka_c = 1; ka_en = 1'b1;
        wait_held(1'b1, "k9_held_wait");
        check("k9_code", key_code_o, 4'd9);
        check("k9_valid", key_valid_o, 1'b1);
        check("k9_col", col_o, 4'b1101);
        repeat (8) step();
        check("k9_col_frozen", col_o, 4'b1101);
        check("k9_still_held", key_held_o, 1'b1);
        pop_one();
        check("k9_popped", key_valid_o, 1'b0);

        // 3: release debounce, then a one-tick glitch
        ka_en = 1'b0;
        wait_held(1'b0, "k9_release_wait");
        check("k9_release_col", col_o, 4'b1011);
        wait_col(4'b1101, "glitch_align");
        ovr_en = 1'b1;
        ovr_val = 4'b1110;
        repeat (4) step();
        check("glitch_col_frozen", col_o, 4'b1101);
        ovr_val = 4'b1111;
        repeat (4) step();
        check("glitch_col_adv", col_o, 4'b1011);
        check("glitch_held", key_held_o, 1'b0);
        check("glitch_valid", key_valid_o, 1'b0);
        ovr_en = 1'b0;

        // 4: overflow on a two-entry queue
        press_release(0, 1, "k1");
        check("k1_code", key_code_o, 4'd1);
        check("k1_valid", key_valid_o, 1'b1);
        press_release(0, 2, "k2");
        check("k2_code_head", key_code_o, 4'd1);
        check("k2_ovf", overflow_o, 1'b0);
        press_release(0, 3, "k3");
        check("k3_ovf", overflow_o, 1'b1);
        check("k3_code_head", key_code_o, 4'd1);
        pop_one();
        check("pop1_code", key_code_o, 4'd2);
        check("pop1_valid", key_valid_o, 1'b1);
        pop_one();
        check("pop2_valid", key_valid_o, 1'b0);
        check("pop2_code_hold", key_code_o, 4'd2);
        check("ovf_sticky", overflow_o, 1'b1);
        ovf_clr_i = 1'b1;
        step();
        ovf_clr_i = 1'b0;
        check("ovf_cleared", overflow_o, 1'b0);

        // 5: two rows at once, then push and pop on a full queue
        ka_r = 1; ka_c = 0; kb_r = 3; kb_c = 0;
        ka_en = 1'b1; kb_en = 1'b1;
        wait_held(1'b1, "k4_held_wait");
        ka_en = 1'b0; kb_en = 1'b0;
        wait_held(1'b0, "k4_release_wait");
        check("k4_code", key_code_o, 4'd4);
        check("k4_valid", key_valid_o, 1'b1);
        press_release(2, 2, "k10");
        check("k10_head", key_code_o, 4'd4);
        wait_col(4'b0111, "pp_align");
        ovr_en = 1'b1;
        ovr_val = 4'b0111;
        repeat (11) step();
        key_ready_i = 1'b1;
        step();
        key_ready_i = 1'b0;
        check("pp_held", key_held_o, 1'b1);
        check("pp_code", key_code_o, 4'd10);
        check("pp_valid", key_valid_o, 1'b1);
        check("pp_ovf", overflow_o, 1'b0);
        ovr_val = 4'b1111;
        wait_held(1'b0, "k15_release_wait");
        pop_one();
        check("pp_pop1_code", key_code_o, 4'd15);
        check("pp_pop1_valid", key_valid_o, 1'b1);
        pop_one();
        check("pp_pop2_valid", key_valid_o, 1'b0);

        // 6: asynchronous reset in the middle of a debounce
        wait_col(4'b1101, "rst6_align");
        ovr_val = 4'b1110;
        repeat (5) step();
        check("rst6_pre_col", col_o, 4'b1101);
        #3 rst = 1'b1;
        #1;
        check("rst6_col", col_o, 4'b1110);
        check("rst6_code", key_code_o, 4'd0);
        check("rst6_valid", key_valid_o, 1'b0);
        check("rst6_held", key_held_o, 1'b0);
        check("rst6_ovf", overflow_o, 1'b0);
        ovr_val = 4'b1111;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst6_rel_col", col_o, 4'b1110);
        repeat (3) step();
        check("rst6_col_3clk", col_o, 4'b1110);
        step();
        check("rst6_col_4clk", col_o, 4'b1101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
